// File: rtl/cla_64bit_adder_pkg.sv
// rtl/cla_64bit_adder_pkg.sv - shared widths and lookahead group sizes for the CLA adder
package cla_64bit_adder_pkg;
    localparam int WIDTH_DEFAULT = 64;
    localparam int GRP           = 4;
    localparam int SEC           = 16;
    localparam int GRP_PER_SEC   = SEC / GRP;
endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit carry-lookahead block with group generate/propagate outputs
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g_grp,
    output logic       p_grp
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        // Every internal carry is a flat sum of products from cin; no ripple.
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum   = p ^ c;
        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
    end
endmodule

// File: rtl/cla_64bit_adder.sv
// rtl/cla_64bit_adder.sv - hierarchical carry-lookahead adder with registered sum/cout/out_valid
module cla_64bit_adder
    import cla_64bit_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);
    localparam int NGRP = WIDTH / GRP;
    localparam int NSEC = WIDTH / SEC;

    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_c;
    logic [NSEC-1:0]  sec_g;
    logic [NSEC-1:0]  sec_p;
    logic [NSEC:0]    sec_c;
    logic [WIDTH-1:0] sum_w;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             valid_d, valid_q;

    for (genvar i = 0; i < NGRP; i++) begin : g_grp
        cla_4bit u_cla (
            .a     (a[i*GRP +: GRP]),
            .b     (b[i*GRP +: GRP]),
            .cin   (grp_c[i]),
            .sum   (sum_w[i*GRP +: GRP]),
            .g_grp (grp_g[i]),
            .p_grp (grp_p[i])
        );
    end

    // Second level: fold four group G/P pairs into one section G/P.
    always_comb begin
        logic prod;
        sec_g = '0;
        sec_p = '0;
        for (int s = 0; s < NSEC; s++) begin
            sec_p[s] = 1'b1;
            for (int m = 0; m < GRP_PER_SEC; m++) begin
                sec_p[s] = sec_p[s] & grp_p[s*GRP_PER_SEC + m];
                prod = grp_g[s*GRP_PER_SEC + m];
                for (int n = m + 1; n < GRP_PER_SEC; n++) begin
                    prod = prod & grp_p[s*GRP_PER_SEC + n];
                end
                sec_g[s] = sec_g[s] | prod;
            end
        end
    end

    // Top level: each section carry (and cout) expanded directly from cin.
    always_comb begin
        logic acc;
        logic prod;
        sec_c = '0;
        for (int k = 0; k <= NSEC; k++) begin
            acc = cin;
            for (int j = 0; j < k; j++) begin
                acc = acc & sec_p[j];
            end
            for (int j = 0; j < k; j++) begin
                prod = sec_g[j];
                for (int m = j + 1; m < k; m++) begin
                    prod = prod & sec_p[m];
                end
                acc = acc | prod;
            end
            sec_c[k] = acc;
        end
    end

    // Group carries inside each section, expanded from that section's carry.
    always_comb begin
        logic acc;
        logic prod;
        grp_c = '0;
        for (int s = 0; s < NSEC; s++) begin
            for (int j = 0; j < GRP_PER_SEC; j++) begin
                acc = sec_c[s];
                for (int m = 0; m < j; m++) begin
                    acc = acc & grp_p[s*GRP_PER_SEC + m];
                end
                for (int m = 0; m < j; m++) begin
                    prod = grp_g[s*GRP_PER_SEC + m];
                    for (int n = m + 1; n < j; n++) begin
                        prod = prod & grp_p[s*GRP_PER_SEC + n];
                    end
                    acc = acc | prod;
                end
                grp_c[s*GRP_PER_SEC + j] = acc;
            end
        end
    end

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum_w;
            cout_d = sec_c[NSEC];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_cla_64bit_adder.sv
// tb/tb_cla_64bit_adder.sv - randomized and directed self-checking bench for cla_64bit_adder
module tb_cla_64bit_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        out_valid;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [64:0] last_exp;

    cla_64bit_adder #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    task automatic add_check(input string tag, input logic [63:0] x, input logic [63:0] y, input logic c);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        last_exp = ref_add(x, y, c);
        @(posedge clk);
        #1;
        check({tag, "_sum"}, {cout, sum}, last_exp);
        check({tag, "_vld"}, {64'd0, out_valid}, 65'd1);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        cin = 1'($urandom);
        @(posedge clk);
        #1;
        check({tag, "_vld"}, {64'd0, out_valid}, 65'd0);
        check({tag, "_hold"}, {cout, sum}, last_exp);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        last_exp = '0;
        #2;
        check("rst_init", {cout, sum}, 65'd0);
        check("rst_init_vld", {64'd0, out_valid}, 65'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        add_check("small0", 64'd20, 64'd55, 1'b0);
        add_check("small1", 64'd24, 64'd133, 1'b1);
        idle_check("small_idle");

        // Reset asserted between edges with a result in flight.
        @(negedge clk);
        in_valid = 1'b1;
        a = 64'd1000;
        b = 64'd2000;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid", {cout, sum}, 65'd0);
        check("rst_mid_vld", {64'd0, out_valid}, 65'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_vld", {64'd0, out_valid}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;

        add_check("med0", 64'd3748, 64'd9786, 1'b0);
        add_check("med1", 64'd655675, 64'd7374670, 1'b1);
        add_check("large", 64'd4223372036854775808, 64'd28701384792384, 1'b1);
        check("large_const", {cout, sum}, {1'b0, 64'd4223400738239568193});
        add_check("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        check("carry_all_const", {cout, sum}, {1'b1, 64'd0});
        add_check("max_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("max_max_const", {cout, sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

        for (int i = 0; i < 3; i++) begin
            add_check("b2b", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end
        idle_check("b2b_idle");

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_check("rnd_idle");
            end else begin
                add_check("rnd", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cla_64bit_adder.md
Name: cla_64bit_adder

Overview:
- 64-bit carry-lookahead adder computing a + b + cin, with registered outputs.
- Used as a single-cycle datapath adder stage in the arithmetic pipeline.
- The combinational hierarchical lookahead core feeds an output register; results appear 1 cycle after capture.

Parameters:
- WIDTH, 64, operand/sum width; must be a multiple of 16 (only 64 is verified).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- cin  input  1  carry in
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry out of the MSB
- out_valid  output  1  sum/cout hold a new result

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: while rst_n=0, sum=0, cout=0, out_valid=0 immediately, regardless of clk.
- Reset is honoured mid-operation; any result in flight is discarded.
- Latency: inputs sampled on a clk rising edge with in_valid=1 appear on sum/cout at that edge's output; out_valid=1 for exactly that cycle.
- Throughput: one operation per cycle, no backpressure.
- in_valid=0 at an edge: out_valid goes 0; sum/cout hold their previous values.
- Arithmetic: full unsigned add of WIDTH+1 bits, {cout,sum} = a + b + cin.
  - Overflow wraps; the dropped bit is reported in cout.
  - No signed overflow flag.
- Core structure:
  - Per-bit generate g=a&b and propagate p=a^b.
  - 4-bit lookahead blocks produce group G/P.
  - A second lookahead level over four 4-bit groups forms 16-bit sections.
  - A top lookahead level over the 16-bit sections computes section carries from cin.
  - sum[i] = p[i] ^ c[i].
  - No ripple chain longer than 4 bits.
- The combinational path must be purely a function of a, b, cin; it contains no latches.
- X on a/b/cin while in_valid=1 may propagate to sum; out_valid must never be X after reset.

Decomposition:
- Shared package: WIDTH default constant; group size constants GRP=4 and SEC=16.
- Sub-module cla_4bit: inputs a[3:0], b[3:0], cin; outputs sum[3:0], group G, group P.
  - Instantiated WIDTH/4 times.
  - Upper lookahead levels are built inline in the top.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> sum=0, cout=0, out_valid=0 immediately; hold 2 cycles, release.
- Small operands:
  - 20+55+0 -> sum=75, cout=0.
  - 24+133+1 -> sum=158, cout=0.
  - Each with out_valid=1 exactly one cycle after capture.
- Medium operands:
  - 3748+9786+0 -> sum=13534, cout=0.
  - 655675+7374670+1 -> sum=8030346, cout=0.
- Large operands: 4223372036854775808+28701384792384+1 -> sum=4223400738239568193, cout=0.
- Carry through all 64 bits: a=0xFFFFFFFFFFFFFFFF, b=0, cin=1 -> sum=0, cout=1.
  - Then a=b=0xFFFFFFFFFFFFFFFF, cin=1 -> sum=0xFFFFFFFFFFFFFFFF, cout=1.
- Back-to-back and idle:
  - Apply three vectors on consecutive cycles -> three consecutive matching results.
  - Then in_valid=0 -> out_valid=0 and sum holds the last value.
  - Random 10k vectors checked against a 65-bit reference add.
